// File: rtl/aes_encryption_iter.sv
// aes_encryption_iter: iterative AES-128/192/256 encryption core.
// One cipher round per clock over a single shared round datapath. The key is
// expanded once, one 32-bit word per cycle, into an internal word buffer and
// reused for every block until the next rekey.
//
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset
//   key_i/key_v_i      cipher key (MSB word is w[0]) and its valid
//   key_ready_o        key accepted when key_v_i & key_ready_o
//   data_i/v_i         plaintext (state byte 0 in [127:120]) and its valid
//   ready_o            plaintext accepted when v_i & ready_o
//   data_o/v_o         ciphertext and its valid, held until yumi_i
//   yumi_i             consumer takes ciphertext
//   zeroize_i          only with AES_ENC_ZEROIZE_EN: wipe key, state, output
//
// Optional feature macro: AES_ENC_ZEROIZE_EN.

module sub_bytes #(
  parameter int BYTES = 16
) (
  input  logic [8*BYTES-1:0] src,
  output logic [8*BYTES-1:0] res
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, s;
    p = 8'h01;
    s = x;
    for (int unsigned k = 0; k < 7; k++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
             ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    res = '0;
    for (int unsigned k = 0; k < BYTES; k++) res[8*k +: 8] = sbox(src[8*k +: 8]);
  end
endmodule

module shift_rows (
  input  logic [127:0] src,
  output logic [127:0] res
);
  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  always_comb begin
    res = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = src[127-8*(4*((c+r)%4)+r) -: 8];
  end
endmodule

module mix_columns (
  input  logic [127:0] src,
  output logic [127:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_comb begin
    res = '0;
    for (int unsigned c = 0; c < 4; c++) res[127-32*c -: 32] = mix_col(src[127-32*c -: 32]);
  end
endmodule

module aes_encryption_iter #(
  parameter int KEY_BITS = 256
) (
  input  logic                clk_i,
  input  logic                reset_i,
`ifdef AES_ENC_ZEROIZE_EN
  input  logic                zeroize_i,
`endif
  input  logic [KEY_BITS-1:0] key_i,
  input  logic                key_v_i,
  output logic                key_ready_o,
  input  logic [127:0]        data_i,
  input  logic                v_i,
  output logic                ready_o,
  output logic [127:0]        data_o,
  output logic                v_o,
  input  logic                yumi_i
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam int RW = $clog2(NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_encryption_iter: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {eIDLE, eKEXP, eWAIT, eROUND, eDONE} state_e;
  state_e st, st_nxt;

  logic [31:0]   w [NW];
  logic [IW-1:0] widx;
  logic [2:0]    kmod;   // widx mod NK, tracked incrementally
  logic [7:0]    rcon;   // Rcon for the next widx with kmod==0
  logic [RW-1:0] round;
  logic [127:0]  state, data_q;
  logic          wipe;

`ifdef AES_ENC_ZEROIZE_EN
  assign wipe = zeroize_i;
`else
  assign wipe = 1'b0;
`endif

  // Key schedule step for word widx.
  logic [31:0] prev_w, sub_in, sub_out, t_w, new_w;
  assign prev_w = w[widx - IW'(1)];
  assign sub_in = (kmod == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  sub_bytes #(.BYTES(4)) u_sub_word (.src(sub_in), .res(sub_out));

  always_comb begin
    t_w = prev_w;
    if (kmod == '0) t_w = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4) t_w = sub_out;
  end
  assign new_w = w[widx - IW'(NK)] ^ t_w;

  // Shared round datapath; the final round taps the pre-MixColumns value.
  logic [127:0]  sb, sr, mc, rk;
  logic [IW-1:0] rk_base;
  sub_bytes #(.BYTES(16)) u_sub_bytes (.src(state), .res(sb));
  shift_rows u_shift_rows (.src(sb), .res(sr));
  mix_columns u_mix_columns (.src(sr), .res(mc));
  assign rk_base = IW'({round, 2'b00});
  assign rk = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};

  always_comb begin
    st_nxt      = st;
    key_ready_o = 1'b0;
    ready_o     = 1'b0;
    unique case (st)
      eIDLE: begin
        key_ready_o = 1'b1;
        if (key_v_i) st_nxt = eKEXP;
      end
      eKEXP:  if (widx == IW'(NW - 1)) st_nxt = eWAIT;
      eWAIT: begin
        key_ready_o = 1'b1;
        ready_o     = ~key_v_i;
        if (key_v_i)  st_nxt = eKEXP;
        else if (v_i) st_nxt = eROUND;
      end
      eROUND: if (round == RW'(NR)) st_nxt = eDONE;
      eDONE:  if (yumi_i) st_nxt = eWAIT;
      default: st_nxt = eIDLE;
    endcase
  end

  assign v_o    = (st == eDONE);
  assign data_o = data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st     <= eIDLE;
      for (int unsigned k = 0; k < NW; k++) w[k] <= '0;
      widx   <= '0;
      kmod   <= '0;
      rcon   <= '0;
      round  <= '0;
      state  <= '0;
      data_q <= '0;
    end else if (wipe) begin
      st     <= eIDLE;
      for (int unsigned k = 0; k < NW; k++) w[k] <= '0;
      round  <= '0;
      state  <= '0;
      data_q <= '0;
    end else begin
      st <= st_nxt;
      unique case (st)
        eIDLE, eWAIT: begin
          if (key_v_i) begin
            for (int unsigned k = 0; k < NK; k++) w[k] <= key_i[KEY_BITS-1-32*k -: 32];
            widx <= IW'(NK);
            kmod <= '0;
            rcon <= 8'h01;
          end else if (st == eWAIT && v_i) begin
            state <= data_i ^ {w[0], w[1], w[2], w[3]};
            round <= RW'(1);
          end
        end
        eKEXP: begin
          w[widx] <= new_w;
          widx    <= widx + IW'(1);
          kmod    <= (kmod == 3'(NK - 1)) ? '0 : kmod + 3'd1;
          if (kmod == '0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
        eROUND: begin
          if (round == RW'(NR)) begin
            data_q <= sr ^ rk;
            round  <= '0;
          end else begin
            state <= mc ^ rk;
            round <= round + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encryption_iter.sv
// Scoreboard bench for aes_encryption_iter: one DUT per key size (128/192/256)
// run concurrently, each with its own driver, consumer and monitor.
module tb_aes_encryption_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  localparam logic [0:2047] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbx(input logic [7:0] x);
    return SBOX_T[int'(x)*8 +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook byte-oriented AES; key is left-justified in 256 bits.
  function automatic logic [127:0] ref_enc(input logic [255:0] key, input int nk,
                                           input logic [127:0] pt);
    logic [7:0] ek [240];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    for (int b = 0; b < 4*nk; b++) ek[b] = key[255-8*b -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) a[j] = ek[4*(i-1)+j];
      if (i % nk == 0) begin
        logic [7:0] a0;
        a0 = a[0];
        a[0] = sbx(a[1]) ^ rc[i/nk-1];
        a[1] = sbx(a[2]);
        a[2] = sbx(a[3]);
        a[3] = sbx(a0);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) a[j] = sbx(a[j]);
      end
      for (int j = 0; j < 4; j++) ek[4*i+j] = ek[4*(i-nk)+j] ^ a[j];
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ ek[b];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbx(s[b]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c+0] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
          s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ ek[16*r+b];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  task automatic chk(input int kb, input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL aes%0d %s: got %h want %h", kb, nm, act, req);
    end
  endtask

  task automatic fail(input int kb, input string nm);
    checks++;
    errors++;
    $display("FAIL aes%0d %s: bound expired", kb, nm);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int KB  = 128 + 64*g;
    localparam int NKL = KB / 32;
    localparam int NRL = NKL + 6;
    localparam logic [127:0] KAT = (KB == 128) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                   (KB == 192) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          reset, key_v, key_ready, v_in, ready, v_out, yumi;
    logic [KB-1:0] key;
    logic [127:0]  din, dout;
`ifdef AES_ENC_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    aes_encryption_iter #(.KEY_BITS(KB)) u_dut (
      .clk_i(clk), .reset_i(reset),
`ifdef AES_ENC_ZEROIZE_EN
      .zeroize_i(zeroize),
`endif
      .key_i(key), .key_v_i(key_v), .key_ready_o(key_ready),
      .data_i(din), .v_i(v_in), .ready_o(ready),
      .data_o(dout), .v_o(v_out), .yumi_i(yumi));

    logic [127:0] exp_q [$];
    int acc_q [$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each new output, checks latency and hold.
    initial begin : mon
      logic pv, py;
      logic [127:0] held;
      pv = 1'b0; py = 1'b0; held = '0;
      forever begin
        @(negedge clk);
        if (!reset && v_in && ready) acc_q.push_back(cyc + 1);
        if (v_out) begin
          chk(KB, "ready_o low while v_o", 128'(ready), 128'(0));
          if (!pv) begin
            if (exp_q.size() == 0) fail(KB, "unexpected output");
            else chk(KB, "ciphertext", dout, exp_q.pop_front());
            if (acc_q.size() != 0) chk(KB, "latency", 128'(cyc - acc_q.pop_front()), 128'(NRL));
          end else if (!py) begin
            chk(KB, "data_o held", dout, held);
          end
        end
        pv = v_out; py = yumi; held = dout;
      end
    end

    // Consumer: first block stalled 5 cycles, later ones randomly; stray yumi while idle.
    initial begin : cons
      int nblk, d;
      nblk = 0;
      yumi = 1'b0;
      forever begin
        @(negedge clk);
        if (v_out) begin
          d = (nblk == 0) ? 5 : int'($urandom_range(0, 3));
          nblk++;
          repeat (d) @(posedge clk);
          #1 yumi = 1'b1;
          @(posedge clk);
          #1 yumi = 1'b0;
        end else if (nblk > 0 && $urandom_range(0, 9) == 0) begin
          @(posedge clk);
          #1 yumi = 1'b1;
          @(posedge clk);
          #1 yumi = 1'b0;
        end
      end
    end

    task automatic wait_key_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!key_ready) begin
        if (++n > 300) begin fail(KB, "wait key_ready"); return; end
        @(negedge clk);
      end
    endtask

    task automatic load_key(input logic [KB-1:0] k, input logic with_data, input logic [127:0] pt);
      int low;
      wait_key_ready();
      @(posedge clk);
      #1 key_v = 1'b1; key = k;
      if (with_data) begin v_in = 1'b1; din = pt; end
      @(negedge clk);
      chk(KB, "key_ready_o at load", 128'(key_ready), 128'(1));
      if (with_data) chk(KB, "ready_o low on key/data collision", 128'(ready), 128'(0));
      @(posedge clk);
      #1 key_v = 1'b0; v_in = 1'b0;
      low = 0;
      while (low < 200) begin
        @(negedge clk);
        if (key_ready) break;
        low++;
      end
      chk(KB, "expansion cycles", 128'(low), 128'(4*(NRL+1) - NKL));
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] e);
      int n;
      n = 0;
      @(posedge clk);
      #1 v_in = 1'b1; din = pt;
      forever begin
        @(negedge clk);
        if (ready) break;
        if (++n > 300) begin fail(KB, "wait ready_o"); v_in = 1'b0; return; end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1 v_in = 1'b0;
    endtask

    initial begin : drv
      logic [255:0] kfull, k2full;
      logic [127:0] pt;
      int n;
      reset = 1'b1; key_v = 1'b0; v_in = 1'b0; key = '0; din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(KB, "reset v_o", 128'(v_out), 128'(0));
      chk(KB, "reset key_ready_o", 128'(key_ready), 128'(1));
      chk(KB, "reset ready_o", 128'(ready), 128'(0));
      chk(KB, "reset data_o", dout, 128'(0));
      reset = 1'b0;

      kfull = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      load_key(kfull[255 -: KB], 1'b0, '0);
      send(128'h00112233445566778899aabbccddeeff, KAT);
      for (int i = 0; i < 3; i++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(pt, ref_enc(kfull, NKL, pt));
      end

      // Rekey with data offered in the same cycle: the key must win.
      k2full = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      pt = 128'h6bc1bee22e409f96e93d7e117393172a;
      load_key(k2full[255 -: KB], 1'b1, pt);
      send(pt, (KB == 256) ? 128'hf3eed1bdb5d2a03c064b5a7e3db181f8 : ref_enc(k2full, NKL, pt));

      // Reset in round 5 of an in-flight block.
      wait_key_ready();
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(pt, ref_enc(k2full, NKL, pt));
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk(KB, "v_o after mid-round reset", 128'(v_out), 128'(0));
      chk(KB, "key_ready_o after mid-round reset", 128'(key_ready), 128'(1));
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      v_in = 1'b1; din = pt;
      repeat (6) begin
        @(negedge clk);
        chk(KB, "ready_o with no key", 128'(ready), 128'(0));
      end
      @(posedge clk);
      #1 v_in = 1'b0;
      repeat (15) @(negedge clk);
      chk(KB, "no output without key", 128'(v_out), 128'(0));

      kfull = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load_key(kfull[255 -: KB], 1'b0, '0);
      for (int i = 0; i < 2; i++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(pt, ref_enc(kfull, NKL, pt));
      end

      n = 0;
      while ((exp_q.size() != 0 || v_out) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk(KB, "scoreboard drained", 128'(exp_q.size()), 128'(0));
      n_done++;
    end
  end

  initial begin : summary
    fork
      wait (n_done == 3);
      #500000;
    join_any
    if (n_done != 3) begin
      errors++;
      $display("FAIL timeout: %0d of 3 sequences finished", n_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_encryption_iter.md
Name: aes_encryption_iter

Overview:
- Iterative, parametrised AES encryption core: one round per clock over a single shared round datapath, instead of an unrolled combinational chain.
- Supports AES-128/192/256, selected by parameter.
- Expands the key once, one 32-bit word per cycle, into an internal word buffer. The expanded key is reused for any number of blocks until the next rekey.
- Sits between bsg-style valid/ready producers and consumers on the chip datapath; reuses the existing sub_bytes, shift_rows and mix_columns leaf modules.

Parameters:
- KEY_BITS, 256, key size; legal values 128/192/256; any other value is an elaboration error.
- NK (localparam), KEY_BITS/32, key words.
- NR (localparam), NK+6, number of rounds (10/12/14).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- key_i  in  KEY_BITS  cipher key; MSB word is w[0], byte order per FIPS-197
- key_v_i  in  1  key valid
- key_ready_o  out  1  key load accepted when key_v_i & key_ready_o
- data_i  in  128  plaintext; state byte 0 in [127:120]
- v_i  in  1  plaintext valid
- ready_o  out  1  plaintext accepted when v_i & ready_o
- data_o  out  128  ciphertext
- v_o  out  1  ciphertext valid
- yumi_i  in  1  consumer takes ciphertext; legal only while v_o=1

Behaviour:
- Reset values (async, immediate): FSM=eIDLE, v_o=0, data_o=0, round counter=0, key-buffer valid flag=0, key_ready_o=1, ready_o=0.
- eIDLE (no key held):
  - key_ready_o=1, ready_o=0.
  - key_v_i → load w[0..NK-1] from key_i, set i=NK, go to eKEXP.
- eKEXP (key expansion):
  - Each cycle computes w[i] = w[i-NK] ^ t, where t = w[i-1] with:
    - i mod NK==0 → t = SubWord(RotWord(t)) ^ {Rcon[i/NK],24'h0}; Rcon = 01,02,04,08,10,20,40,80,1b,36.
    - NK==8 and i mod NK==4 → t = SubWord(t).
  - Then i++.
  - Done after i = 4*(NR+1)-1 → eWAIT. Duration is 40/46/52 cycles for 128/192/256.
  - key_ready_o=0, ready_o=0 throughout.
- eWAIT (key held, idle):
  - key_ready_o=1; ready_o = ~key_v_i, so key has priority.
  - key_v_i → rekey exactly as from eIDLE; any held key is overwritten.
  - v_i & ready_o → state <= data_i ^ {w0..w3}, round=1, go to eROUND.
- eROUND:
  - Each cycle: state <= ShiftRows/SubBytes/MixColumns(state) ^ {w[4r]..w[4r+3]}, then round++.
  - When round==NR, MixColumns is skipped and the result is registered into data_o; go to eDONE.
  - key_ready_o=0, ready_o=0.
- eDONE:
  - v_o=1; data_o held stable until yumi_i.
  - yumi_i → v_o=0, go to eWAIT. The next block can be accepted one cycle later.
  - key_ready_o=0, ready_o=0.
- Latency: v_o rises exactly NR cycles after the accepting clock edge.
- Throughput: one block per NR+2 cycles with yumi_i tied high.
- Boundary conditions:
  - key_v_i and v_i asserted in the same eWAIT cycle → key accepted, data not accepted.
  - Rekey is impossible in eKEXP, eROUND and eDONE.
  - yumi_i while v_o=0 is ignored.
  - reset_i at any point, including mid-expansion or mid-round, discards the key buffer and any in-flight block and returns to eIDLE. v_o drops asynchronously.
  - Round counter width is clog2(NR+1); it never wraps.

Optional Feature:
- Macro: AES_ENC_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize_i (1 bit).
  - When high at a clock edge, all key-buffer words, the state register and data_o are cleared to 0, v_o=0, and the FSM goes to eIDLE. This overrides every other input except reset_i.
- Undefined: the port and its logic are absent. The key buffer is cleared only by reset_i or overwritten by a rekey.

Test Plan:
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → data_o=69c4e0d86a7b0430d8cdb78070b4c55a; key_ready_o low for 40 cycles; v_o 10 cycles after accept.
- KEY_BITS=192, key 000102…1617, same pt → dda97ca4864cdfe06eaf70a0ec0d7191; v_o 12 cycles after accept.
- KEY_BITS=256, key 000102…1e1f, same pt → 8ea2b7ca516745bfeafc49904b496089.
- KEY_BITS=256, then rekey in eWAIT with key_v_i and v_i both high, key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, followed by pt 6bc1bee22e409f96e93d7e117393172a → data not taken in the collision cycle; output f3eed1bdb5d2a03c064b5a7e3db181f8.
- Back-to-back under backpressure: hold yumi_i=0 for 5 cycles after v_o → data_o stable and ready_o=0 throughout. After yumi_i, a second block under the same key, with no re-expansion, gives the correct ciphertext.
- Assert reset_i in round 5 → v_o=0 and key_ready_o=1 immediately. A v_i pulse afterwards is not accepted until a new key is loaded and expanded.
